vga_timing_gen: RTL

- Parametrised raster timing generator; successor to the fixed 640x480 VGA counter block.
- Runs from the system clock with an internal pixel clock-enable, so no divided clocks are generated.
- Provides registered sync, active and coordinate outputs, line/frame strobes, a frame counter, and a lead ("fetch") coordinate LEAD pixels ahead for framebuffer reads with latency.
- Sits between the framebuffer/vector renderer and the video output.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_axis_counter.sv | 41 ++++
 rtl/vga_timing_gen.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared state encodings, standard 640x480@60 timing constants and small
// elaboration-time helpers for the raster timing generator.
package vga_timing_pkg;

  typedef logic [1:0] vga_state_t;

  localparam vga_state_t ST_IDLE  = 2'd0;
  localparam vga_state_t ST_RUN   = 2'd1;
  localparam vga_state_t ST_DRAIN = 2'd2;

  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;

  function automatic int unsigned axis_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic logic in_window(input int unsigned v, input int unsigned lo,
                                     input int unsigned len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with enable, plus decode of the value the
// counter takes after this edge so the owner can register outputs in step.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned ACTIVE     = 640,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_LEN   = 96,
  parameter int unsigned CW         = 11
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          en,
  output logic          last_c,
  output logic [CW-1:0] nxt_c,
  output logic          act_nxt_c,
  output logic          sync_nxt_c
);

  logic [CW-1:0] cnt;

  always_comb begin
    last_c = (cnt == CW'(TOTAL - 1));
    nxt_c  = cnt;
    if (en) begin
      nxt_c = last_c ? '0 : cnt + CW'(1);
    end
    act_nxt_c  = (nxt_c < CW'(ACTIVE));
    sync_nxt_c = in_window(32'(nxt_c), SYNC_START, SYNC_LEN);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt <= '0;
    end else begin
      cnt <= nxt_c;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator on a pixel clock-enable, with
// registered sync/active/coordinates, strobes, frame count and lead fetch.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
  parameter int unsigned H_FP     = VGA640_H_FP,
  parameter int unsigned H_SYNC   = VGA640_H_SYNC,
  parameter int unsigned H_BP     = VGA640_H_BP,
  parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
  parameter int unsigned V_FP     = VGA640_V_FP,
  parameter int unsigned V_SYNC   = VGA640_V_SYNC,
  parameter int unsigned V_BP     = VGA640_V_BP,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned PIX_DIV  = 4,
  parameter int unsigned LEAD     = 2,
  parameter int unsigned CW       = 11,
  parameter int unsigned FCW      = 8
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           run,
  output logic           pix_ce,
  output logic           hsync,
  output logic           vsync,
  output logic           active,
  output logic [CW-1:0]  col,
  output logic [CW-1:0]  row,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt,
  output logic           fetch_valid,
  output logic [CW-1:0]  fetch_col,
  output logic [CW-1:0]  fetch_row
);

  localparam int unsigned H_TOTAL      = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL      = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned DW           = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  vga_state_t    state;
  vga_state_t    state_nxt_c;
  logic [DW-1:0] div;
  logic [DW-1:0] div_nxt_c;
  logic          adv_c;
  logic          h_en_c;
  logic          v_en_c;
  logic          disp_c;
  logic          frame_last_c;

  logic          h_last_c, v_last_c;
  logic [CW-1:0] h_nxt_c, v_nxt_c;
  logic          h_act_c, v_act_c, h_sync_c, v_sync_c;
  logic          vis_c;
  logic          fs_c;

  logic [CW:0]   fh_sum_c, fv_sum_c;
  logic          fh_wrap_c, fv_wrap_c;
  logic [CW-1:0] fh_c, fv_c;
  logic          fvis_c;

  // Free-running divider; the pixel advances on the edge that enters pix_ce.
  always_comb begin
    div_nxt_c = (div == DW'(PIX_DIV - 1)) ? '0 : div + DW'(1);
    adv_c     = (div_nxt_c == DW'(PIX_DIV - 1));
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      div <= '0;
    end else begin
      div <= div_nxt_c;
    end
  end

  assign h_en_c       = adv_c && (state != ST_IDLE);
  assign v_en_c       = h_en_c && h_last_c;
  assign frame_last_c = h_last_c && v_last_c;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_SYNC_START),
    .SYNC_LEN   (H_SYNC),
    .CW         (CW)
  ) u_hcnt (
    .clk        (clk),
    .rst_l      (rst_l),
    .en         (h_en_c),
    .last_c     (h_last_c),
    .nxt_c      (h_nxt_c),
    .act_nxt_c  (h_act_c),
    .sync_nxt_c (h_sync_c)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_SYNC_START),
    .SYNC_LEN   (V_SYNC),
    .CW         (CW)
  ) u_vcnt (
    .clk        (clk),
    .rst_l      (rst_l),
    .en         (v_en_c),
    .last_c     (v_last_c),
    .nxt_c      (v_nxt_c),
    .act_nxt_c  (v_act_c),
    .sync_nxt_c (v_sync_c)
  );

  // Leaving a running frame with run low drops straight to IDLE at frame end.
  always_comb begin
    state_nxt_c = state;
    if (adv_c) begin
      case (state)
        ST_IDLE: begin
          if (run) state_nxt_c = ST_RUN;
        end
        ST_RUN, ST_DRAIN: begin
          if (frame_last_c && !run) state_nxt_c = ST_IDLE;
          else                      state_nxt_c = run ? ST_RUN : ST_DRAIN;
        end
        default: state_nxt_c = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt_c;
    end
  end

  // Lead position: single carry is enough because LEAD < H_TOTAL.
  always_comb begin
    disp_c    = (state_nxt_c != ST_IDLE);
    vis_c     = h_act_c && v_act_c;
    fs_c      = (h_nxt_c == '0) && (v_nxt_c == '0);
    fh_sum_c  = {1'b0, h_nxt_c} + (CW+1)'(LEAD);
    fh_wrap_c = (fh_sum_c >= (CW+1)'(H_TOTAL));
    fh_c      = fh_wrap_c ? CW'(fh_sum_c - (CW+1)'(H_TOTAL)) : CW'(fh_sum_c);
    fv_sum_c  = {1'b0, v_nxt_c} + (CW+1)'(fh_wrap_c);
    fv_wrap_c = (fv_sum_c >= (CW+1)'(V_TOTAL));
    fv_c      = fv_wrap_c ? '0 : CW'(fv_sum_c);
    fvis_c    = (fh_c < CW'(H_ACTIVE)) && (fv_c < CW'(V_ACTIVE));
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pix_ce      <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      active      <= 1'b0;
      col         <= '0;
      row         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      fetch_valid <= 1'b0;
      fetch_col   <= '0;
      fetch_row   <= '0;
    end else begin
      pix_ce      <= adv_c;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (adv_c) begin
        if (!disp_c) begin
          hsync       <= ~HS_POL;
          vsync       <= ~VS_POL;
          active      <= 1'b0;
          col         <= '0;
          row         <= '0;
          frame_cnt   <= '0;
          fetch_valid <= 1'b0;
          fetch_col   <= '0;
          fetch_row   <= '0;
        end else begin
          hsync       <= h_sync_c ? HS_POL : ~HS_POL;
          vsync       <= v_sync_c ? VS_POL : ~VS_POL;
          active      <= vis_c;
          col         <= vis_c ? h_nxt_c : '0;
          row         <= vis_c ? v_nxt_c : '0;
          line_start  <= (h_nxt_c == '0);
          frame_start <= fs_c;
          // The first frame after IDLE is frame 0; later frame starts count.
          if (state == ST_IDLE) frame_cnt <= '0;
          else if (fs_c)        frame_cnt <= frame_cnt + FCW'(1);
          fetch_valid <= fvis_c && !(fv_wrap_c && !run);
          fetch_col   <= fvis_c ? fh_c : '0;
          fetch_row   <= fvis_c ? fv_c : '0;
        end
      end
    end
  end

endmodule
